// File: rtl/pix_mem_arbiter.sv
// -----------------------------------------------------------------------------
// pix_mem_arbiter
//
// Single-port pixel-memory arbiter and sequencer. One pixel RAM is shared by
// the CPU MEM stage (pixel loads / memPixWrite stores) and the video scan-out
// reader. Video has priority. A CPU request may only be passed over
// MAX_CPU_WAIT times in a row before the CPU is forced through. While a CPU
// access is pending, cpu_stall tells the hazard unit to hold the pipeline.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cpu_req/we/addr/wdata    CPU request (level, held until cpu_done)
//   cpu_rdata, cpu_done      registered read data, one-cycle completion pulse
//   cpu_stall                cpu_req & ~cpu_done, to the hazard unit
//   vid_req/addr             video read request (level, held until vid_valid)
//   vid_rdata, vid_valid     registered read data, one-cycle completion pulse
//   mem_en/we/addr/wdata     RAM strobe and command, driven in the grant cycle
//   mem_rdata                RAM read data, MEM_LAT cycles after the strobe
// -----------------------------------------------------------------------------
module pix_mem_arbiter #(
    parameter int ADDR_W       = 18,
    parameter int DATA_W       = 32,
    parameter int MEM_LAT      = 2,
    parameter int MAX_CPU_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_stall,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_valid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int LAT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int WAIT_W = $clog2(MAX_CPU_WAIT + 1);

    localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(MEM_LAT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_CPU_WAIT);

    typedef enum logic [1:0] {
        IDLE,
        RD_CPU,
        RD_VID,
        WR_CPU
    } state_t;

    state_t            state, state_nxt;
    logic [LAT_W-1:0]  lat_cnt, lat_cnt_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;

    logic port_free;
    logic cpu_elig, vid_elig;
    logic grant_cpu, grant_vid;
    logic cap_cpu, cap_vid;

    // -------------------------------------------------------------------------
    // Arbitration, next state and RAM command
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves
        // one unassigned; that is what keeps this block from inferring latches.
        state_nxt    = state;
        lat_cnt_nxt  = lat_cnt;
        wait_cnt_nxt = wait_cnt;
        grant_cpu    = 1'b0;
        grant_vid    = 1'b0;

        port_free = (state == IDLE) || (state == WR_CPU) ||
                    (((state == RD_CPU) || (state == RD_VID)) && (lat_cnt == '0));

        // A requester showing its completion pulse this cycle is still holding
        // the level for the access just finished; it must not be granted again.
        cpu_elig = cpu_req & ~cpu_done;
        vid_elig = vid_req & ~vid_valid;

        if (port_free && !rst) begin
            if (cpu_elig && (!vid_elig || (wait_cnt == WAIT_MAX))) begin
                grant_cpu = 1'b1;
            end else if (vid_elig) begin
                grant_vid = 1'b1;
            end
        end

        if (grant_cpu) begin
            state_nxt   = cpu_we ? WR_CPU : RD_CPU;
            lat_cnt_nxt = LAT_LOAD;
        end else if (grant_vid) begin
            state_nxt   = RD_VID;
            lat_cnt_nxt = LAT_LOAD;
        end else if (port_free) begin
            state_nxt = IDLE;
        end else begin
            lat_cnt_nxt = lat_cnt - 1'b1;
        end

        if (!cpu_req || grant_cpu) begin
            wait_cnt_nxt = '0;
        end else if (grant_vid && (wait_cnt != WAIT_MAX)) begin
            wait_cnt_nxt = wait_cnt + 1'b1;
        end

        // mem_rdata is sampled at the end of the cycle before the pulse. With a
        // one-cycle RAM that is the grant cycle itself; otherwise it is the read
        // state's cycle with one latency step left.
        if (MEM_LAT == 1) begin
            cap_cpu = grant_cpu & ~cpu_we;
            cap_vid = grant_vid;
        end else begin
            cap_cpu = (state == RD_CPU) && (lat_cnt == LAT_W'(1));
            cap_vid = (state == RD_VID) && (lat_cnt == LAT_W'(1));
        end

        mem_en    = grant_cpu | grant_vid;
        mem_we    = grant_cpu & cpu_we;
        mem_addr  = grant_cpu ? cpu_addr : (grant_vid ? vid_addr : '0);
        mem_wdata = (grant_cpu && cpu_we) ? cpu_wdata : '0;

        cpu_stall = cpu_req & ~cpu_done;
    end

    // -------------------------------------------------------------------------
    // State, counters and registered outputs
    // -------------------------------------------------------------------------
    // NOTE: reset is synchronous, so it is tested inside the clocked block and
    // is not in the sensitivity list; an in-flight access is simply dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            wait_cnt  <= '0;
            cpu_done  <= 1'b0;
            vid_valid <= 1'b0;
            cpu_rdata <= '0;
            vid_rdata <= '0;
        end else begin
            state     <= state_nxt;
            lat_cnt   <= lat_cnt_nxt;
            wait_cnt  <= wait_cnt_nxt;
            cpu_done  <= cap_cpu | (grant_cpu & cpu_we);
            vid_valid <= cap_vid;
            // Read data registers hold between pulses; writes leave cpu_rdata alone.
            if (cap_cpu) cpu_rdata <= mem_rdata;
            if (cap_vid) vid_rdata <= mem_rdata;
        end
    end

endmodule
